// File: rtl/ap_ctrl_txn_recorder.sv
// Observes one block's ap_ctrl handshake and emits one timestamped record per completed
// transaction on a valid/ready stream, buffered so consumer back-pressure never stalls the block.
module ap_ctrl_txn_recorder #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ID_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_t_start,
  output logic [CNT_W-1:0] rec_t_ready,
  output logic [CNT_W-1:0] rec_t_done,
  output logic [CNT_W-1:0] rec_stall,
  output logic [15:0]      drop_cnt,
  output logic             busy,
  output logic             flushed
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] t_start;
    logic [CNT_W-1:0] t_ready;
    logic [CNT_W-1:0] t_done;
    logic [CNT_W-1:0] stall;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] t_start_q, t_start_d;
  logic [CNT_W-1:0] t_ready_q, t_ready_d;
  logic [CNT_W-1:0] t_done_q, t_done_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             ready_seen_q, ready_seen_d;
  logic [15:0]      drop_q, drop_d;
  logic             fin_seen_q, fin_seen_d;
  logic             flushed_q, flushed_d;
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  rec_t             mem_q [FIFO_DEPTH];
  rec_t             mem_d [FIFO_DEPTH];

  logic             run_eval;
  logic             close;
  rec_t             rec_close;
  logic             empty, full, pop, push, drop;
  logic [PtrW-1:0]  wr_idx, rd_idx;
  rec_t             head;

  // Transaction tracking. An open from IDLE evaluates ready/done in the same cycle as RUN would.
  always_comb begin
    state_d      = state_q;
    t_start_d    = t_start_q;
    t_ready_d    = t_ready_q;
    t_done_d     = t_done_q;
    stall_d      = stall_q;
    ready_seen_d = ready_seen_q;
    run_eval     = 1'b0;
    close        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          t_start_d    = cyc_q;
          t_ready_d    = '0;
          t_done_d     = '0;
          stall_d      = '0;
          ready_seen_d = 1'b0;
          run_eval     = 1'b1;
        end
      end
      StRun: run_eval = 1'b1;
      StHold: begin
        if (ap_done && !ap_continue) stall_d = sat_inc(stall_q);
        if (ap_continue) begin
          close   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (run_eval) begin
      state_d = StRun;
      if (ap_ready && !ready_seen_d) begin
        t_ready_d    = cyc_q;
        ready_seen_d = 1'b1;
      end
      if (ap_done) begin
        t_done_d = cyc_q;
        if (!ready_seen_d) t_ready_d = cyc_q;
        if (ap_continue) begin
          close   = 1'b1;
          state_d = StIdle;
        end else begin
          // The done cycle itself already counts as a stalled cycle.
          stall_d = sat_inc(stall_d);
          state_d = StHold;
        end
      end
    end

    rec_close.id      = id_q;
    rec_close.t_start = t_start_d;
    rec_close.t_ready = t_ready_d;
    rec_close.t_done  = t_done_d;
    rec_close.stall   = stall_d;
  end

  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
  assign pop    = !empty && rec_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign push   = close && (!full || pop);
  assign drop   = close && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_idx] = rec_close;
      wr_ptr_d      = wr_ptr_q + PtrOne;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_comb begin
    cyc_d      = cyc_q + CNT_W'(1);
    id_d       = close ? id_q + ID_W'(1) : id_q;
    drop_d     = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    fin_seen_d = fin_seen_q | finish;
    flushed_d  = flushed_q | ((fin_seen_q | finish) && state_q == StIdle && empty);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cyc_q        <= '0;
      id_q         <= '0;
      t_start_q    <= '0;
      t_ready_q    <= '0;
      t_done_q     <= '0;
      stall_q      <= '0;
      ready_seen_q <= 1'b0;
      drop_q       <= '0;
      fin_seen_q   <= 1'b0;
      flushed_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      id_q         <= id_d;
      t_start_q    <= t_start_d;
      t_ready_q    <= t_ready_d;
      t_done_q     <= t_done_d;
      stall_q      <= stall_d;
      ready_seen_q <= ready_seen_d;
      drop_q       <= drop_d;
      fin_seen_q   <= fin_seen_d;
      flushed_q    <= flushed_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign head        = mem_q[rd_idx];
  assign rec_valid   = !empty;
  assign rec_id      = rec_valid ? head.id : '0;
  assign rec_t_start = rec_valid ? head.t_start : '0;
  assign rec_t_ready = rec_valid ? head.t_ready : '0;
  assign rec_t_done  = rec_valid ? head.t_done : '0;
  assign rec_stall   = rec_valid ? head.stall : '0;
  assign drop_cnt    = drop_q;
  assign busy        = (state_q != StIdle);
  assign flushed     = flushed_q;

endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// Bench for ap_ctrl_txn_recorder: directed scenarios with literal expectations, then random
// handshake traffic compared every cycle against a transaction-level model with a record queue.
module tb_ap_ctrl_txn_recorder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
  logic        finish = 1'b0, rec_ready = 1'b0;
  logic        rec_valid, busy, flushed;
  logic [15:0] rec_id, drop_cnt;
  logic [31:0] rec_t_start, rec_t_ready, rec_t_done, rec_stall;

  always #5 clock = ~clock;

  ap_ctrl_txn_recorder #(
    .CNT_W      (32),
    .ID_W       (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .finish      (finish),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_id      (rec_id),
    .rec_t_start (rec_t_start),
    .rec_t_ready (rec_t_ready),
    .rec_t_done  (rec_t_done),
    .rec_stall   (rec_stall),
    .drop_cnt    (drop_cnt),
    .busy        (busy),
    .flushed     (flushed)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] id;
    logic [31:0] ts, tr, td, st;
  } mrec_t;

  // Model: transaction fields plus a plain queue of pending records.
  logic [31:0] m_cyc, m_ts, m_tr, m_td, m_stl;
  logic [15:0] m_id, m_drop;
  bit          m_open, m_rseen, m_dseen, m_fin, m_flushed;
  mrec_t       m_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit    was_open;
    int    qn;
    bit    pop;
    bit    close;
    mrec_t r;
    if (reset) begin
      m_cyc = 0; m_id = 0; m_drop = 0; m_open = 0; m_rseen = 0; m_dseen = 0;
      m_fin = 0; m_flushed = 0; m_ts = 0; m_tr = 0; m_td = 0; m_stl = 0;
      m_q.delete();
      return;
    end
    was_open  = m_open;
    qn        = m_q.size();
    pop       = (qn > 0) && rec_ready;
    close     = 0;
    m_flushed = m_flushed | ((m_fin | finish) && !was_open && qn == 0);
    m_fin     = m_fin | finish;
    if (!m_open && ap_start) begin
      m_open = 1; m_ts = m_cyc; m_rseen = 0; m_dseen = 0; m_stl = 0;
    end
    if (m_open) begin
      if (!m_dseen) begin
        if (ap_ready && !m_rseen) begin m_tr = m_cyc; m_rseen = 1; end
        if (ap_done) begin
          m_td = m_cyc;
          if (!m_rseen) m_tr = m_cyc;
          m_dseen = 1;
        end
      end
      if (m_dseen) begin
        if (ap_done && !ap_continue && m_stl != 32'hFFFF_FFFF) m_stl++;
        if (ap_continue) close = 1;
      end
    end
    if (pop) m_q.delete(0);
    if (close) begin
      r.id = m_id; r.ts = m_ts; r.tr = m_tr; r.td = m_td; r.st = m_stl;
      if (qn < 4 || pop) m_q.push_back(r);
      else if (m_drop != 16'hFFFF) m_drop++;
      m_id++;
      m_open = 0;
    end
    m_cyc++;
  endtask

  task automatic compare();
    chk("busy", busy, m_open);
    chk("rec_valid", rec_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("rec_id", rec_id, m_q[0].id);
      chk("rec_t_start", rec_t_start, m_q[0].ts);
      chk("rec_t_ready", rec_t_ready, m_q[0].tr);
      chk("rec_t_done", rec_t_done, m_q[0].td);
      chk("rec_stall", rec_stall, m_q[0].st);
    end
    chk("drop_cnt", drop_cnt, m_drop);
    chk("flushed", flushed, m_flushed);
  endtask

  // Called at a negedge: drive inputs for the current cycle, then land in the next cycle.
  task automatic step(input bit rst, input bit st, input bit rd, input bit dn, input bit co,
                      input bit fin, input bit rr);
    reset = rst; ap_start = st; ap_ready = rd; ap_done = dn; ap_continue = co;
    finish = fin; rec_ready = rr;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    chk("rst_valid", rec_valid, 0);
    chk("rst_id", rec_id, 0);
    chk("rst_t_start", rec_t_start, 0);
    chk("rst_stall", rec_stall, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flushed", flushed, 0);

    // Basic transaction.
    for (int c = 0; c < 12; c++) begin
      step(0, c >= 2 && c <= 5, c == 5, c == 9, c == 9, 0, 1);
      if (c + 1 == 3) chk("basic_busy", busy, 1);
      if (c + 1 == 9) chk("basic_not_yet", rec_valid, 0);
      if (c + 1 == 10) begin
        chk("basic_valid", rec_valid, 1);
        chk("basic_id", rec_id, 0);
        chk("basic_start", rec_t_start, 2);
        chk("basic_ready", rec_t_ready, 5);
        chk("basic_done", rec_t_done, 9);
        chk("basic_stall", rec_stall, 0);
      end
      if (c + 1 == 11) begin
        chk("basic_valid_gone", rec_valid, 0);
        chk("basic_busy_gone", busy, 0);
      end
    end

    // Continue held back three cycles after done.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      step(0, c >= 2 && c <= 5, c == 5, c >= 9 && c <= 12, c == 12, 0, 1);
      if (c + 1 == 12) chk("stall_hold_busy", busy, 1);
      if (c + 1 == 13) begin
        chk("stall_valid", rec_valid, 1);
        chk("stall_cnt", rec_stall, 3);
        chk("stall_done", rec_t_done, 9);
        chk("stall_ready", rec_t_ready, 5);
      end
    end

    // Single-cycle combinational transaction followed immediately by another.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(0, c == 4 || c == 5, c == 4 || c == 6, c == 4 || c == 7, c == 4 || c == 7, 0, 1);
      if (c + 1 == 5) begin
        chk("comb_valid", rec_valid, 1);
        chk("comb_start", rec_t_start, 4);
        chk("comb_ready", rec_t_ready, 4);
        chk("comb_done", rec_t_done, 4);
        chk("comb_stall", rec_stall, 0);
      end
      if (c + 1 == 6) chk("comb_busy2", busy, 1);
      if (c + 1 == 8) begin
        chk("comb_id2", rec_id, 1);
        chk("comb_start2", rec_t_start, 5);
      end
    end

    // Overflow: six closes into a four-entry FIFO with no consumer.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(0, c % 2 == 1 && c < 12, c % 2 == 1 && c < 12, c % 2 == 1 && c < 12,
           c % 2 == 1 && c < 12, 0, 0);
    end
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_valid", rec_valid, 1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", rec_id, 16'(k));
      step(0, 0, 0, 0, 0, 0, 1);
    end
    chk("ovf_empty", rec_valid, 0);
    step(0, 1, 1, 1, 1, 0, 1);
    chk("ovf_id7", rec_id, 6);

    // Reset in the middle of a running transaction.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      step(c == 6, c >= 3, 0, 0, 0, 0, 1);
      if (c + 1 == 5) chk("rstmid_busy", busy, 1);
    end
    chk("rstmid_busy_after", busy, 0);
    chk("rstmid_no_rec", rec_valid, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 1, 0, 1);
    chk("rstmid_cyc_restart", rec_t_start, 1);
    chk("rstmid_id", rec_id, 0);

    // Finish with two records queued behind a stalled consumer.
    do_reset();
    for (int c = 0; c < 15; c++) begin
      step(0, c == 1 || c == 3, c == 1 || c == 3, c == 1 || c == 3, c == 1 || c == 3,
           c == 5, c >= 9);
      if (c + 1 == 8) begin
        chk("fin_not_flushed", flushed, 0);
        chk("fin_queued", rec_valid, 1);
      end
      if (c + 1 == 11) begin
        chk("fin_drained", rec_valid, 0);
        chk("fin_wait", flushed, 0);
      end
      if (c + 1 == 12) chk("fin_flushed", flushed, 1);
      if (c + 1 == 15) chk("fin_sticky", flushed, 1);
    end

    // Random handshake traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5, $urandom_range(0, 399) == 0,
           $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_txn_recorder.md
# ap_ctrl_txn_recorder

Synthesizable companion to the cosim dataflow monitors: watches one block's ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue) and turns each completed transaction into a timestamped record on a valid/ready stream. It sits directly upstream of the CSV dump path, which pops records and writes module-status rows. Records are buffered in a small FIFO so that consumer back-pressure never stalls the observed design; overflow drops records and counts them.

## Interface
- CNT_W, 32: width of cycle counter and all timestamps.
- ID_W, 16: width of transaction id.
- FIFO_DEPTH, 4: record FIFO entries; must be a power of two, ≥2.

- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- ap_start, ap_ready, ap_done, ap_continue  in  1 each  observed handshake of the monitored block.
- finish  in  1  testbench end-of-run indication.
- rec_valid  out  1  record available at FIFO head.
- rec_ready  in  1  consumer accepts head when rec_valid & rec_ready.
- rec_id  out  ID_W  transaction index.
- rec_t_start, rec_t_ready, rec_t_done  out  CNT_W each  cycle stamps.
- rec_stall  out  CNT_W  cycles ap_done was high with ap_continue low.
- drop_cnt  out  16  records lost to FIFO full, saturating at 0xFFFF.
- busy  out  1  transaction open (state ≠ IDLE).
- flushed  out  1  sticky: finish seen, idle, FIFO drained.

## Operation
- cyc: free-running CNT_W counter; 0 in first cycle after reset deasserts, +1 per cycle, wraps modulo 2^CNT_W; stamps are raw values (no unwrapping).
- FSM states IDLE, RUN, HOLD.
- IDLE: on ap_start=1 open txn; t_start=cyc, ready_seen=0, stall=0. Same-cycle ap_ready and/or ap_done are also captured this cycle (evaluated as in RUN).
- RUN: first cycle with ap_ready=1 sets t_ready=cyc, ready_seen=1; later ap_ready pulses ignored. On ap_done=1: t_done=cyc; if ready_seen=0 and ap_ready=0 then t_ready=t_done. If ap_continue=1 same cycle → close, IDLE; else → HOLD.
- HOLD: each cycle with ap_done=1 & ap_continue=0 increments stall (saturating); on ap_continue=1 → close, IDLE.
- ap_start high in RUN/HOLD is the current txn's start, not a new one. A new txn opens only from IDLE, earliest the cycle after close.
- Close: push {id, t_start, t_ready, t_done, stall} into FIFO; id increments on every close, including dropped ones, wrapping at 2^ID_W.
- FIFO full at close with no pop this cycle → record discarded, drop_cnt+1 (saturating). Full with simultaneous pop → push accepted.
- flushed set when finish has been seen (latched) & state IDLE & FIFO empty; stays 1 until reset. Finish during RUN/HOLD waits for close and drain.
- Reset at any point (including mid-txn or FIFO non-empty): state IDLE, FIFO emptied, open txn discarded without record.

## Timing
- Reset values: rec_valid=0, rec_id/rec_t_*/rec_stall=0, drop_cnt=0, busy=0, flushed=0; cyc=0, id=0.
- Record latency: close edge cycle N → rec_valid=1 in cycle N+1 (FIFO empty case).
- Head outputs stable while rec_valid=1 & rec_ready=0; advance one entry per accepted cycle; full-throughput back-to-back pops.
- busy=1 from cycle after open through close cycle; 0 the cycle after close.
- flushed asserts one cycle after its condition first holds.

## Test plan
- Basic: start at cyc 2 (held to ready), ready cyc 5, done & continue cyc 9, rec_ready=1 → one record id 0, start 2, ready 5, done 9, stall 0; rec_valid high in cyc 10 only.
- Back-pressure stall: done at cyc 9, continue at cyc 12 → stall 3, t_done 9, record valid cyc 13.
- Combinational block: start/ready/done/continue all 1 in cyc 4 → start=ready=done=4, stall 0; second txn opened cyc 5 gets id 1.
- Overflow: rec_ready=0, 6 txns closed → 4 records ids 0–3, drop_cnt 2; then rec_ready=1 → ids 0,1,2,3 in order; 7th txn record id 6.
- Reset mid-RUN (start cyc 3, reset cyc 6) → no record, busy=0, cyc restarts at 0 after reset.
- Finish with 2 records queued, rec_ready low → flushed=0; raise rec_ready → flushed=1 one cycle after FIFO empties, remains 1.
